hist_eq_frame_ctrl: RTL and testbench
=====================================

# hist_eq_frame_ctrl

Frame-level sequencer for the Y-channel histogram-equalization datapath in the RGB→YCbCr→HistEQ→RGB video chain. It gates histogram accumulation per frame and validates the pixel count. During vertical blanking it scans the 256-bin histogram RAM to build the cumulative distribution (CDF) into the inactive LUT bank, then clears the histogram and swaps LUT banks. The apply stage always uses a complete LUT from the last valid frame.

## Interface
- IMG_TOTAL, 480000, required active pixels (href-high cycles) per frame
- CNT_W, 19, width of pixel counter, histogram bins and CDF; must hold IMG_TOTAL

- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- per_img_vsync  in  1  active-high frame-valid level
- per_img_href  in  1  active-high pixel valid
- hist_acc_en  out  1  increment enable to histogram RAM; combinational per_img_href AND state==ACCUM
- hist_addr  out  8  histogram address for clear and read
- hist_clr  out  1  write zero to hist_addr
- hist_rd_en  out  1  read strobe at hist_addr
- hist_rd_data  in  CNT_W  bin count, valid 1 cycle after hist_rd_en
- lut_we  out  1  LUT write strobe
- lut_waddr  out  8  LUT write address
- lut_wdata  out  CNT_W  inclusive CDF value
- lut_wbank  out  1  bank being written; always ~lut_bank_sel
- lut_bank_sel  out  1  bank used by apply stage
- frame_done  out  1  1-cycle pulse on LUT swap
- busy  out  1  state != IDLE
- err_size  out  1  sticky: accepted frame had pixel count != IMG_TOTAL
- drop_cnt  out  8  frames ignored because controller busy; saturates at 255

## Operation
- vsync_d register; rise = vsync & ~vsync_d; fall = ~vsync & vsync_d.
- States: INIT_CLR, IDLE, ACCUM, SCAN, CLEAR, SWAP.
- Reset → INIT_CLR: hist_clr=1, hist_addr 0..255 over 256 cycles → IDLE.
- IDLE: rise → ACCUM, pix_cnt=0, cdf=0. fall is ignored.
- Any rise while state != IDLE → drop_cnt+1 (saturating). Frame ignored; hist_acc_en stays 0 for it.
- ACCUM: pix_cnt+1 per href cycle, saturating at 2^CNT_W-1. On fall:
  - pix_cnt==IMG_TOTAL → SCAN.
  - otherwise → err_size=1, then CLEAR, skipping SCAN and SWAP.
- SCAN: hist_rd_en=1 with hist_addr 0..255 on cycles 0..255.
  - On cycles 1..256: cdf += hist_rd_data; lut_we=1, lut_waddr=prior read address, lut_wdata=updated cdf.
  - 257 cycles total, then CLEAR.
- CLEAR: hist_clr=1, hist_addr 0..255 over 256 cycles.
  - Entered from SCAN → SWAP.
  - Entered from error path → IDLE.
- SWAP: lut_bank_sel toggles and frame_done=1 for this single cycle → IDLE.
- Arithmetic: cdf is CNT_W bits, no wrap for valid frames. Final lut_wdata (addr 255) must equal IMG_TOTAL.
- No LUT write ever targets the bank selected by lut_bank_sel.

## Timing
- Reset values (asserted asynchronously):
  - 0: hist_clr, hist_rd_en, lut_we, frame_done, lut_bank_sel, err_size, drop_cnt, hist_addr, lut_waddr, lut_wdata, pix_cnt, cdf.
  - Outputs that follow from state INIT_CLR: busy=1, hist_acc_en=0.
- Reset mid-operation aborts everything. LUT contents are not guaranteed, and the bench must not check them until the first frame_done.
- ACCUM is entered the cycle after rise. href in the rise cycle is not counted; sources keep ≥1 cycle between vsync rise and first href.
- Fall cycle: href in that cycle is still counted if state==ACCUM.
- Valid-frame post-processing: fall → SCAN entry +1 cycle, SCAN 257, CLEAR 256, SWAP 1. frame_done occurs 515 cycles after the fall cycle; IDLE follows on the next cycle.
- Error path: CLEAR ends 257 cycles after fall; no frame_done.
- Vertical blanking must be ≥516 cycles or the next frame is dropped.
- rise and fall never occur in the same cycle, since they are level-derived.

## Test plan
- Release reset with vsync low → hist_clr high 256 consecutive cycles, addr 0..255 → busy drops on the next cycle; no frame_done; lut_bank_sel=0.
- IMG_TOTAL=16: frame of 16 href cycles; model returns bin5=16, other bins 0.
  - lut_wdata=0 for addr 0..4 and 16 for addr 5..255, all in bank 1.
  - Then 256 clears, frame_done pulse, lut_bank_sel 0→1.
- IMG_TOTAL=16: frame of 15 pixels → err_size=1, zero lut_we, 256 clears, no frame_done, lut_bank_sel unchanged.
- Second vsync rise 100 cycles after the first frame's fall → drop_cnt=1; hist_acc_en=0 through that frame; first frame's frame_done still occurs at fall+515.
- Assert rst_n low at SCAN cycle 100 → all outputs at reset values immediately, err_size=0, lut_bank_sel=0. After release, a fresh 256-cycle INIT_CLR runs.
- Two valid frames with 600-cycle blanking → two frame_done pulses, lut_bank_sel 0→1→0, drop_cnt=0, err_size=0.

Source files
------------

// File: rtl/hist_eq_frame_ctrl.sv
// Frame sequencer for Y-channel histogram equalization: gates accumulation, checks pixel count,
// builds the CDF into the inactive LUT bank during blanking, then clears the histogram and swaps banks.
module hist_eq_frame_ctrl #(
    parameter int unsigned IMG_TOTAL = 480000,
    parameter int unsigned CNT_W     = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             per_img_vsync,
    input  logic             per_img_href,
    output logic             hist_acc_en,
    output logic [7:0]       hist_addr,
    output logic             hist_clr,
    output logic             hist_rd_en,
    input  logic [CNT_W-1:0] hist_rd_data,
    output logic             lut_we,
    output logic [7:0]       lut_waddr,
    output logic [CNT_W-1:0] lut_wdata,
    output logic             lut_wbank,
    output logic             lut_bank_sel,
    output logic             frame_done,
    output logic             busy,
    output logic             err_size,
    output logic [7:0]       drop_cnt
);

    localparam int unsigned SEQ_W = 9;
    localparam logic [SEQ_W-1:0] SEQ_LAST = 9'd256;

    localparam logic [2:0] ST_INIT_CLR = 3'd0;
    localparam logic [2:0] ST_IDLE     = 3'd1;
    localparam logic [2:0] ST_ACCUM    = 3'd2;
    localparam logic [2:0] ST_SCAN     = 3'd3;
    localparam logic [2:0] ST_CLEAR    = 3'd4;
    localparam logic [2:0] ST_SWAP     = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic             vsync_q, fall_q;
    logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [CNT_W-1:0] cdf_q, cdf_d;
    logic             from_scan_q, from_scan_d;
    logic [7:0]       hist_addr_q, hist_addr_d;
    logic             hist_clr_q, hist_clr_d;
    logic             hist_rd_en_q, hist_rd_en_d;
    logic             lut_we_q, lut_we_d;
    logic [7:0]       lut_waddr_q, lut_waddr_d;
    logic [CNT_W-1:0] lut_wdata_q, lut_wdata_d;
    logic             bank_q, bank_d;
    logic             frame_done_q, frame_done_d;
    logic             err_q, err_d;
    logic [7:0]       drop_q, drop_d;

    logic             vsync_rise, vsync_fall;
    logic [CNT_W-1:0] cdf_sum;

    assign vsync_rise = per_img_vsync & ~vsync_q;
    assign vsync_fall = ~per_img_vsync & vsync_q;
    assign cdf_sum    = cdf_q + hist_rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_INIT_CLR;
            seq_q        <= '0;
            vsync_q      <= 1'b0;
            fall_q       <= 1'b0;
            pix_cnt_q    <= '0;
            cdf_q        <= '0;
            from_scan_q  <= 1'b0;
            hist_addr_q  <= '0;
            hist_clr_q   <= 1'b0;
            hist_rd_en_q <= 1'b0;
            lut_we_q     <= 1'b0;
            lut_waddr_q  <= '0;
            lut_wdata_q  <= '0;
            bank_q       <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
            drop_q       <= '0;
        end else begin
            state_q      <= state_d;
            seq_q        <= seq_d;
            vsync_q      <= per_img_vsync;
            fall_q       <= vsync_fall;
            pix_cnt_q    <= pix_cnt_d;
            cdf_q        <= cdf_d;
            from_scan_q  <= from_scan_d;
            hist_addr_q  <= hist_addr_d;
            hist_clr_q   <= hist_clr_d;
            hist_rd_en_q <= hist_rd_en_d;
            lut_we_q     <= lut_we_d;
            lut_waddr_q  <= lut_waddr_d;
            lut_wdata_q  <= lut_wdata_d;
            bank_q       <= bank_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
            drop_q       <= drop_d;
        end
    end

    // Strobes are registered against the next state so they line up with the state they belong to.
    always_comb begin
        state_d      = state_q;
        seq_d        = seq_q;
        pix_cnt_d    = pix_cnt_q;
        cdf_d        = cdf_q;
        from_scan_d  = from_scan_q;
        hist_addr_d  = '0;
        hist_clr_d   = 1'b0;
        hist_rd_en_d = 1'b0;
        lut_we_d     = 1'b0;
        lut_waddr_d  = lut_waddr_q;
        lut_wdata_d  = lut_wdata_q;
        bank_d       = bank_q;
        frame_done_d = 1'b0;
        err_d        = err_q;
        drop_d       = drop_q;

        case (state_q)
            ST_INIT_CLR: begin
                if (seq_q == SEQ_LAST) begin
                    state_d = ST_IDLE;
                    seq_d   = '0;
                end else begin
                    hist_clr_d  = 1'b1;
                    hist_addr_d = seq_q[7:0];
                    seq_d       = seq_q + 9'd1;
                end
            end
            ST_IDLE: begin
                if (vsync_rise) begin
                    state_d   = ST_ACCUM;
                    pix_cnt_d = '0;
                    cdf_d     = '0;
                end
            end
            ST_ACCUM: begin
                if (per_img_href && (pix_cnt_q != {CNT_W{1'b1}})) begin
                    pix_cnt_d = pix_cnt_q + CNT_W'(1);
                end
                // fall_q gives the fall-cycle pixel one clock to land in pix_cnt_q
                if (fall_q) begin
                    seq_d = 9'd1;
                    if (pix_cnt_q == CNT_W'(IMG_TOTAL)) begin
                        state_d      = ST_SCAN;
                        hist_rd_en_d = 1'b1;
                        from_scan_d  = 1'b1;
                    end else begin
                        state_d     = ST_CLEAR;
                        hist_clr_d  = 1'b1;
                        err_d       = 1'b1;
                        from_scan_d = 1'b0;
                    end
                end
            end
            ST_SCAN: begin
                // seq_q = k means the read for address k-1 is on the bus; data for k-2 has arrived
                if (seq_q >= 9'd2) begin
                    cdf_d       = cdf_sum;
                    lut_we_d    = 1'b1;
                    lut_waddr_d = 8'(seq_q - 9'd2);
                    lut_wdata_d = cdf_sum;
                end
                if (seq_q < SEQ_LAST) begin
                    hist_rd_en_d = 1'b1;
                    hist_addr_d  = seq_q[7:0];
                    seq_d        = seq_q + 9'd1;
                end else if (seq_q == SEQ_LAST) begin
                    seq_d = seq_q + 9'd1;
                end else begin
                    state_d    = ST_CLEAR;
                    hist_clr_d = 1'b1;
                    seq_d      = 9'd1;
                end
            end
            ST_CLEAR: begin
                if (seq_q == SEQ_LAST) begin
                    seq_d = '0;
                    if (from_scan_q) begin
                        state_d      = ST_SWAP;
                        frame_done_d = 1'b1;
                        bank_d       = ~bank_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    hist_clr_d  = 1'b1;
                    hist_addr_d = seq_q[7:0];
                    seq_d       = seq_q + 9'd1;
                end
            end
            ST_SWAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_INIT_CLR;
                seq_d   = '0;
            end
        endcase

        if (vsync_rise && (state_q != ST_IDLE) && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    assign hist_acc_en  = per_img_href && (state_q == ST_ACCUM);
    assign hist_addr    = hist_addr_q;
    assign hist_clr     = hist_clr_q;
    assign hist_rd_en   = hist_rd_en_q;
    assign lut_we       = lut_we_q;
    assign lut_waddr    = lut_waddr_q;
    assign lut_wdata    = lut_wdata_q;
    assign lut_wbank    = ~bank_q;
    assign lut_bank_sel = bank_q;
    assign frame_done   = frame_done_q;
    assign busy         = (state_q != ST_IDLE);
    assign err_size     = err_q;
    assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_hist_eq_frame_ctrl.sv
// Bench for hist_eq_frame_ctrl: histogram RAM model, randomized frames, and a scoreboard that
// matches every LUT write and frame_done pulse against CDFs computed from the pixels driven.
module tb_hist_eq_frame_ctrl;

    localparam int unsigned IMG = 16;
    localparam int unsigned CW  = 19;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          vsync   = 1'b0;
    logic          href    = 1'b0;
    logic [7:0]    pix_val = 8'd0;
    logic [CW-1:0] rd_data;

    logic          hist_acc_en, hist_clr, hist_rd_en, lut_we, lut_wbank, lut_bank_sel;
    logic          frame_done, busy, err_size;
    logic [7:0]    hist_addr, lut_waddr, drop_cnt;
    logic [CW-1:0] lut_wdata;

    hist_eq_frame_ctrl #(.IMG_TOTAL(IMG), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .per_img_vsync(vsync), .per_img_href(href),
        .hist_acc_en(hist_acc_en), .hist_addr(hist_addr), .hist_clr(hist_clr),
        .hist_rd_en(hist_rd_en), .hist_rd_data(rd_data), .lut_we(lut_we),
        .lut_waddr(lut_waddr), .lut_wdata(lut_wdata), .lut_wbank(lut_wbank),
        .lut_bank_sel(lut_bank_sel), .frame_done(frame_done), .busy(busy),
        .err_size(err_size), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Histogram RAM: garbage while in reset, so only the controller's clears make it usable.
    int unsigned ram [256];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) ram[i] <= $urandom_range(1, 40);
            rd_data <= '0;
        end else begin
            if (hist_rd_en)  rd_data <= CW'(ram[hist_addr]);
            if (hist_clr)    ram[hist_addr] <= 0;
            if (hist_acc_en) ram[pix_val] <= ram[pix_val] + 1;
        end
    end

    typedef struct { logic [7:0] addr; logic [CW-1:0] data; logic bank; } lut_exp_t;
    typedef struct { int cyc; logic bank; } done_exp_t;
    lut_exp_t  lut_q[$];
    done_exp_t done_q[$];
    bit        exp_bank  = 1'b0;
    int        clr_total = 0;
    int        we_total  = 0;
    int        done_total = 0;

    always @(negedge clk) begin : mon
        lut_exp_t  e;
        done_exp_t d;
        if (rst_n) begin
            if (hist_clr) clr_total++;
            if (lut_we) begin
                we_total++;
                if (lut_q.size() == 0) chk("lut_we_unexpected", 1, 0);
                else begin
                    e = lut_q.pop_front();
                    chk("lut_waddr", lut_waddr, e.addr);
                    chk("lut_wdata", lut_wdata, e.data);
                    chk("lut_wbank", lut_wbank, e.bank);
                    chk("lut_write_to_active_bank", lut_wbank == lut_bank_sel, 0);
                end
            end
            if (frame_done) begin
                done_total++;
                if (done_q.size() == 0) chk("frame_done_unexpected", 1, 0);
                else begin
                    d = done_q.pop_front();
                    chk("frame_done_cycle", cyc, d.cyc);
                    chk("bank_sel_at_swap", lut_bank_sel, d.bank);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: uniform random, 1: every pixel in bin 5, 2: only bins 0 and 255
    task automatic send_frame(input int npix, input int mode, input bit accept, output int fall_cyc);
        int hist [256];
        int bad, cdf, v, gap;
        bit last_on_fall;
        bad = 0;
        for (int i = 0; i < 256; i++) hist[i] = 0;
        tick(); vsync = 1'b1; href = 1'b0;
        tick(); tick();
        last_on_fall = ($urandom_range(0, 1) == 1) && (npix > 0);
        for (int p = 0; p < npix; p++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) begin tick(); href = 1'b0; end
            tick();
            case (mode)
                1:       v = 5;
                2:       v = ($urandom_range(0, 1) == 1) ? 255 : 0;
                default: v = $urandom_range(0, 255);
            endcase
            pix_val = 8'(v);
            href = 1'b1;
            hist[v]++;
            if (p == npix - 1 && last_on_fall) vsync = 1'b0;
            #2;
            if (hist_acc_en !== accept) bad++;
        end
        if (!last_on_fall) begin tick(); href = 1'b0; vsync = 1'b0; end
        fall_cyc = cyc;
        if (accept && npix == IMG) begin
            cdf = 0;
            for (int a = 0; a < 256; a++) begin
                cdf += hist[a];
                lut_q.push_back('{addr: 8'(a), data: CW'(cdf), bank: !exp_bank});
            end
            done_q.push_back('{cyc: fall_cyc + 515, bank: !exp_bank});
            exp_bank = !exp_bank;
        end
        tick(); href = 1'b0;
        chk(accept ? "acc_en_accepted_frame" : "acc_en_dropped_frame", bad, 0);
    endtask

    task automatic wait_idle(input string name, input int exp_cyc);
        int n = 0;
        while (busy === 1'b1 && n < 3000) begin @(negedge clk); n++; end
        chk({name, "_idle"}, busy, 0);
        chk({name, "_idle_cycle"}, cyc, exp_cyc);
        chk({name, "_lut_q_drained"}, lut_q.size(), 0);
        chk({name, "_done_q_drained"}, done_q.size(), 0);
    endtask

    task automatic check_init(input int done_before);
        int n = 0;
        int bad = 0;
        @(negedge clk);
        while (hist_clr !== 1'b1 && n < 8) begin @(negedge clk); n++; end
        for (int i = 0; i < 256; i++) begin
            if (!(hist_clr === 1'b1 && hist_addr === 8'(i))) bad++;
            if (i < 255) @(negedge clk);
        end
        chk("init_clr_seq", bad, 0);
        chk("init_busy_during", busy, 1);
        @(negedge clk);
        chk("init_busy_drop", busy, 0);
        chk("init_clr_off", hist_clr, 0);
        chk("init_bank_sel", lut_bank_sel, 0);
        chk("init_no_frame_done", done_total, done_before);
    endtask

    task automatic check_reset_values();
        chk("rst_hist_clr", hist_clr, 0);
        chk("rst_hist_rd_en", hist_rd_en, 0);
        chk("rst_lut_we", lut_we, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_bank_sel", lut_bank_sel, 0);
        chk("rst_err_size", err_size, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_hist_addr", hist_addr, 0);
        chk("rst_lut_waddr", lut_waddr, 0);
        chk("rst_lut_wdata", lut_wdata, 0);
        chk("rst_busy", busy, 1);
        chk("rst_acc_en", hist_acc_en, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int f, f2, clr0, we0, done0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_values();
        rst_n = 1'b1;
        check_init(done_total);

        // valid frame, every pixel in bin 5
        clr0 = clr_total; we0 = we_total;
        send_frame(IMG, 1, 1'b1, f);
        wait_idle("bin5", f + 516);
        chk("bin5_clears", clr_total - clr0, 256);
        chk("bin5_writes", we_total - we0, 256);
        chk("bin5_bank_sel", lut_bank_sel, 1);
        chk("bin5_err", err_size, 0);

        // short frame, then long frame: both error path
        repeat (10) tick();
        clr0 = clr_total; we0 = we_total; done0 = done_total;
        send_frame(IMG - 1, 0, 1'b1, f);
        wait_idle("short", f + 258);
        chk("short_err", err_size, 1);
        chk("short_writes", we_total - we0, 0);
        chk("short_clears", clr_total - clr0, 256);
        chk("short_no_done", done_total - done0, 0);
        chk("short_bank_sel", lut_bank_sel, 1);
        repeat (10) tick();
        we0 = we_total;
        send_frame(IMG + 1, 0, 1'b1, f);
        wait_idle("long", f + 258);
        chk("long_err", err_size, 1);
        chk("long_writes", we_total - we0, 0);

        // second rise 100 cycles after a valid frame's fall is dropped
        repeat (10) tick();
        send_frame(IMG, 2, 1'b1, f);
        while (cyc < f + 99) tick();
        send_frame(8, 0, 1'b0, f2);
        wait_idle("drop", f + 516);
        chk("drop_cnt_1", drop_cnt, 1);
        chk("drop_bank_sel", lut_bank_sel, 0);

        // minimum blanking: next rise exactly 516 cycles after the fall is accepted
        repeat (10) tick();
        send_frame(IMG, 0, 1'b1, f);
        while (cyc < f + 515) tick();
        send_frame(IMG, 0, 1'b1, f2);
        wait_idle("min_blank", f2 + 516);
        chk("min_blank_drop_cnt", drop_cnt, 1);
        chk("min_blank_bank_sel", lut_bank_sel, 0);

        // reset during SCAN cycle 100
        repeat (10) tick();
        send_frame(IMG, 0, 1'b1, f);
        while (cyc < f + 101) tick();
        tick();
        chk("scan_rd_en_100", hist_rd_en, 1);
        chk("scan_addr_100", hist_addr, 100);
        rst_n = 1'b0;
        #1;
        check_reset_values();
        lut_q.delete();
        done_q.delete();
        exp_bank = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        check_init(done_total);

        // two valid frames with 600-cycle blanking
        done0 = done_total;
        send_frame(IMG, 0, 1'b1, f);
        wait_idle("pair_a", f + 516);
        chk("pair_a_bank_sel", lut_bank_sel, 1);
        while (cyc < f + 599) tick();
        send_frame(IMG, 2, 1'b1, f2);
        wait_idle("pair_b", f2 + 516);
        chk("pair_done_count", done_total - done0, 2);
        chk("pair_bank_sel", lut_bank_sel, 0);
        chk("pair_drop_cnt", drop_cnt, 0);
        chk("pair_err", err_size, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
